// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, reset PC default, PC step and the
// buffered fetch entry layout used by fetch, decode, execute and the latch.
package fetch_unit_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP          = 32'h0000_0004;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = ADDR_W + INSTR_W;

  // Force an address onto a word boundary (low two bits cleared).
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with push/pop/flush and an occupancy
// count. Pop on empty is ignored; push on full is only taken together with a
// pop. Flush empties the FIFO and takes priority over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Next-state for storage, pointers and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
    do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter, issues in-order instruction fetches
// under a credit limit (in flight + buffered < BUF_DEPTH), tags each request
// with its PC, buffers returned instructions and presents them to the
// fetch/decode latch. A redirect flushes the buffer and discards every
// response still owed for requests issued before it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(BUF_DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
  logic [INSTR_W-1:0] last_instr_q, last_instr_d;

  logic [CNT_W-1:0]   in_flight_s;
  logic [CNT_W-1:0]   buf_count_s;
  logic [ADDR_W-1:0]  tag_pc_s;
  logic [ENTRY_W-1:0] buf_head_raw_s;
  fetch_entry_t       buf_head_s;
  fetch_entry_t       buf_push_entry_s;
  logic [SUM_W-1:0]   occupancy_s;
  logic               credit_s;
  logic               req_valid_s;
  logic               accept_s;
  logic               buf_push_s;
  logic               buf_pop_s;
  logic               buf_nonempty_s;

  // Tag queue: PC of every accepted request, popped as responses return.
  // Its occupancy doubles as the in-flight count.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (BUF_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept_s),
    .push_data (fetch_pc_q),
    .pop       (imem_resp_valid),
    .pop_data  (tag_pc_s),
    .count     (in_flight_s)
  );

  // Output buffer of {pc, instr} entries presented downstream.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (buf_push_s),
    .push_data (buf_push_entry_s),
    .pop       (buf_pop_s),
    .pop_data  (buf_head_raw_s),
    .count     (buf_count_s)
  );

  // Credit check, request handshake and buffer push/pop decisions.
  always_comb begin
    occupancy_s      = {1'b0, in_flight_s} + {1'b0, buf_count_s};
    credit_s         = occupancy_s < CREDIT_LIMIT;
    req_valid_s      = credit_s & ~redirect_valid & ~reset;
    accept_s         = req_valid_s & imem_req_ready;
    buf_nonempty_s   = buf_count_s != {CNT_W{1'b0}};
    buf_pop_s        = buf_nonempty_s & ~stall;
    buf_head_s       = fetch_entry_t'(buf_head_raw_s);
    buf_push_entry_s = '{pc: tag_pc_s, instr: imem_resp_data};
    // A response arriving during a redirect or while drops are owed is stale.
    buf_push_s       = imem_resp_valid & ~redirect_valid & (drop_cnt_q == {CNT_W{1'b0}});
  end

  // Next fetch PC and the count of stale responses still to be discarded.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      // Everything in flight after this cycle belongs to the old stream; a
      // response arriving now is already dropped and no longer in flight.
      drop_cnt_d = in_flight_s - CNT_W'(imem_resp_valid);
    end else begin
      if (accept_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (imem_resp_valid && (drop_cnt_q != {CNT_W{1'b0}})) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Remember the most recently presented entry so pc/instr hold when empty.
  always_comb begin
    last_pc_d    = last_pc_q;
    last_instr_d = last_instr_q;
    if (buf_nonempty_s) begin
      last_pc_d    = buf_head_s.pc;
      last_instr_d = buf_head_s.instr;
    end else begin
      last_pc_d    = last_pc_q;
      last_instr_d = last_instr_q;
    end
  end

  // Fetch state registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      drop_cnt_q   <= {CNT_W{1'b0}};
      last_pc_q    <= 32'h0000_0000;
      last_instr_q <= 32'h0000_0000;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      drop_cnt_q   <= drop_cnt_d;
      last_pc_q    <= last_pc_d;
      last_instr_q <= last_instr_d;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign valid          = buf_nonempty_s;
  assign pc             = buf_nonempty_s ? buf_head_s.pc    : last_pc_q;
  assign instr          = buf_nonempty_s ? buf_head_s.instr : last_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order instruction memory with random latency,
// random stall/ready/redirect/reset, and a stream-level reference model
// (expected request address, expected presented pc, outstanding work).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        valid;
  logic [31:0] pc, instr;

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .valid           (valid),
    .pc              (pc),
    .instr           (instr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Memory: accepted requests awaiting their response, in order.
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  bit          pend_stale[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_max = 1;

  // Stream model.
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_out = RST_PC;
  int          live = 0;   // accepted, not-stale, not yet consumed
  bit          after_reset = 1'b0;
  int          since_reset = 0;
  int          first_valid_at = -1;
  logic        last_valid;
  logic        last_req_valid;
  logic [31:0] obs_pc, obs_instr;

  function automatic int nonstale_pending();
    int n = 0;
    foreach (pend_stale[i]) if (!pend_stale[i]) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs, sample at negedge, check, update model.
  task automatic do_cycle(input logic st, input logic rv, input logic [31:0] rpc,
                          input logic rdy, input logic rst);
    int buffered, occ, lat, due;
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clk);
    buffered       = live - nonstale_pending();
    occ            = pend_addr.size() + buffered;
    last_valid     = valid;
    last_req_valid = imem_req_valid;
    obs_pc         = pc;
    obs_instr      = instr;
    if (rst) begin
      check_val("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
      pend_addr.delete(); pend_due.delete(); pend_stale.delete();
      last_due = cyc; live = 0;
      exp_req = RST_PC; exp_out = RST_PC;
      after_reset = 1'b1; since_reset = 0; first_valid_at = -1;
    end else begin
      if (after_reset) begin
        check_val("reset_pc", pc, 32'h0000_0000);
        check_val("reset_instr", instr, 32'h0000_0000);
        after_reset = 1'b0;
      end
      check_val("req_valid", 32'(imem_req_valid), 32'((occ < DEPTH) && !rv));
      check_val("req_addr", imem_req_addr, exp_req);
      check_val("valid", 32'(valid), 32'(buffered > 0));
      if (buffered > 0) begin
        check_val("pc", pc, exp_out);
        check_val("instr", instr, mem_word(exp_out));
      end
      if (first_valid_at < 0 && valid) first_valid_at = since_reset;
      since_reset++;
      if (imem_resp_valid) begin
        void'(pend_addr.pop_front()); void'(pend_due.pop_front()); void'(pend_stale.pop_front());
      end
      if (buffered > 0 && !st) begin
        exp_out += 32'd4;
        live--;
      end
      if (imem_req_valid && rdy) begin
        lat = $urandom_range(lat_max, 1);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        pend_addr.push_back(imem_req_addr); pend_due.push_back(due); pend_stale.push_back(1'b0);
        exp_req += 32'd4;
        live++;
      end
      if (rv) begin
        foreach (pend_stale[i]) pend_stale[i] = 1'b1;
        live = 0;
        exp_req = {rpc[31:2], 2'b00};
        exp_out = {rpc[31:2], 2'b00};
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Run unstalled until an entry is presented (bounded); found=1 if seen.
  task automatic run_until_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (last_valid) found = 1'b1;
    end
  endtask

  initial begin
    bit          found;
    logic [31:0] rpc;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    @(posedge clk); #1;

    // Reset release, 1-cycle memory, no stall.
    lat_max = 1;
    repeat (2) do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    repeat (10) do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("first_valid_cycle", 32'(first_valid_at), 32'd2);

    // Long stall: fetch fills credit then stops; release drains in order.
    repeat (10) do_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("stall_req_blocked", 32'(last_req_valid), 32'd0);
    check_val("stall_valid_held", 32'(last_valid), 32'd1);
    repeat (8) do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Redirect with requests in flight (2-cycle memory).
    lat_max = 2;
    repeat (3) do_cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    run_until_valid(found);
    check_val("redir_found", 32'(found), 32'd1);
    check_val("redir_first_pc", obs_pc, 32'h0000_0100);

    // Unaligned redirect target.
    do_cycle(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0);
    check_val("unaligned_req_addr", imem_req_addr, 32'h0000_0200);
    run_until_valid(found);
    check_val("unaligned_first_pc", obs_pc, 32'h0000_0200);

    // Redirect coinciding with a response and stall.
    lat_max = 1;
    for (int i = 0; i < 10 && !(pend_addr.size() > 0 && pend_due[0] <= cyc); i++)
      do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_val("resp_scheduled", 32'(pend_addr.size() > 0 && pend_due[0] <= cyc), 32'd1);
    do_cycle(1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    check_val("redir_resp_valid_next", 32'(last_valid), 32'd0);

    // Wrap at the top of the address space.
    do_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    run_until_valid(found);
    check_val("wrap_first_pc", obs_pc, 32'hFFFF_FFFC);
    run_until_valid(found);
    check_val("wrap_second_pc", obs_pc, 32'h0000_0000);

    // Reset mid-stream.
    repeat (3) do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    check_val("midreset_valid", 32'(last_valid), 32'd0);
    check_val("midreset_addr", imem_req_addr, RST_PC);
    check_val("midreset_pc", obs_pc, 32'h0000_0000);

    // Randomised traffic.
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      do_cycle($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, rpc,
               $urandom_range(9, 0) < 7, $urandom_range(299, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Producer side of the fetch-to-decode pipeline interface. Owns the program counter and issues in-order instruction-memory requests. Buffers returned instructions and presents pc/instr/valid to the fetch/decode pipeline latch, which captures an entry on any cycle where valid=1 and stall=0. Handles branch/jump redirects by discarding stale in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
BUF_DEPTH, 2, combined credit limit: requests in flight plus entries held in the output buffer; power of two, 2..8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall  in  1  downstream stall; when 1, the head entry is not consumed
redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
redirect_pc  in  32  new fetch address; bits[1:0] are ignored and forced to 0
imem_req_valid  out  1  request to instruction memory
imem_req_addr  out  32  word-aligned fetch address
imem_req_ready  in  1  memory accepts the request when valid&ready
imem_resp_valid  in  1  response strobe; in order, at least 1 cycle after acceptance, never back-pressured
imem_resp_data  in  32  instruction word
valid  out  1  pc/instr hold a fetched instruction
pc  out  32  address of the presented instruction
instr  out  32  presented instruction

Behaviour:
- Reset values: fetch_pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, valid=0, pc=0, instr=0. In-flight count, drop count and buffer are all cleared.
- Memory is reset by the same reset. Responses to requests issued before reset never arrive.
- Credit rule: in_flight + buf_count < BUF_DEPTH. This guarantees every accepted response has a buffer slot, so no response back-pressure is needed.
- imem_req_valid = credit available & ~redirect_valid & ~reset. imem_req_addr = fetch_pc.
- Request acceptance (req_valid & req_ready):
  - fetch_pc += 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - in_flight++.
  - The request's PC is pushed into an in-order tag queue of depth BUF_DEPTH.
- Response arrival:
  - Pop the tag queue; in_flight--.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise: push {tag_pc, imem_resp_data} into the output buffer.
- Output: valid = buffer non-empty; pc/instr = buffer head.
  - Pop when valid & ~stall.
  - When the buffer is empty, pc/instr hold their last value.
- Latency: response at cycle N gives valid=1 at cycle N+1 (registered buffer; no combinational response-to-output path).
- Push and pop in the same cycle are both performed; buffer count is unchanged.
- Redirect (cycle N):
  - At N+1: fetch_pc = {redirect_pc[31:2],2'b00}, buffer flushed, valid=0.
  - drop_cnt = current in-flight count, excluding any response arriving at N.
  - A response arriving in cycle N is itself discarded.
  - No request is issued in cycle N.
  - The first redirected request can issue at N+1.
  - Redirect takes priority over stall.
  - A consume in cycle N still completes: the downstream latch sees valid&~stall. The decode side kills it via its own flush.
- Back-to-back redirects: the second redirect re-snapshots drop_cnt as (outstanding drop_cnt + new non-dropped in-flight). Only the last target survives.
- Stall held indefinitely: fetch continues until the credit limit is reached, then imem_req_valid=0. Nothing is lost.
- Reset mid-operation overrides all events in the same cycle.

Decomposition:
- Shared package/header: RESET_PC default, INSTR_W=32, ADDR_W=32, PC_STEP=4.
- The same header serves decode, execute and the latch.
- One natural sub-module: fetch_fifo, a parameterised synchronous FIFO (width, depth) with push/pop/flush and count. Instantiate it twice: tag queue (32b) and output buffer (64b).
- fetch_unit holds the PC, credit logic and drop counter.

Test Plan:
- Reset release, always-ready memory with 1-cycle latency, stall=0 -> req addrs 0x0,0x4,0x8...; valid from cycle 3 after reset; pc/instr pairs match memory in order, one per cycle.
- stall=1 for 10 cycles from pc=0x8 -> exactly BUF_DEPTH requests outstanding/buffered, then req_valid=0. On release: 0x8,0xC delivered with no loss or duplication.
- redirect_valid with redirect_pc=0x100 while 2 requests are in flight -> both stale responses dropped, next valid output has pc=0x100, and no pc from before the redirect appears afterwards.
- redirect_pc=0x203 -> first request addr 0x200, presented pc=0x200.
- Redirect in the same cycle as imem_resp_valid and stall=1 -> response dropped; valid=0 next cycle; buffer empty.
- Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000. Assert reset mid-stream -> all outputs return to reset values next cycle and fetch restarts at RESET_PC.
